// File: rtl/sensor_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sensor_scan_ctrl                                                 |
// | Purpose : Round-robin ADC scan of four sensor channels with dust-LED pulse |
// |           and per-channel power-of-two averaging.                          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sensor_scan_ctrl #(
   parameter int PERIOD_CYC     = 500_000,
   parameter int LED_ON_CYC     = 16_000,
   parameter int DUST_SAMPLE_AT = 15_000,
   parameter int SETTLE_CYC     = 500,
   parameter int AVG_LOG2       = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_adc_data,
   input  logic [3:0] i_ch_en,
   output logic [1:0] o_mux_sel,
   output logic       o_led_en,
   output logic [7:0] o_result,
   output logic [1:0] o_result_ch,
   output logic       o_result_vld,
   output logic       o_busy
);

   localparam int c_fcnt_w = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam int c_acc_w  = 8 + AVG_LOG2;
   localparam logic [c_fcnt_w-1:0] c_last      = c_fcnt_w'(PERIOD_CYC - 1);
   localparam logic [c_fcnt_w-1:0] c_dust_at   = c_fcnt_w'(DUST_SAMPLE_AT);
   localparam logic [c_fcnt_w-1:0] c_settle_at = c_fcnt_w'(SETTLE_CYC);
   localparam logic [c_fcnt_w-1:0] c_led_end   = c_fcnt_w'(LED_ON_CYC);

   typedef enum logic [1:0] {
      S_PICK = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_fcnt_w-1:0]  r_fcnt;
   logic [c_fcnt_w-1:0]  w_cap_at;
   logic [1:0]           r_cur, w_pick_ch;
   logic                 w_found, w_capture;
   logic [c_acc_w-1:0]   r_acc [4];
   logic [AVG_LOG2-1:0]  r_cnt [4];
   logic [c_acc_w-1:0]   w_sum;
   logic [7:0]           r_sample;
   logic                 r_cap_vld;
   logic [1:0]           r_cap_ch;
   logic [1:0]           r_mux_sel;
   logic                 r_led_en;
   logic [7:0]           r_result;
   logic [1:0]           r_result_ch;
   logic                 r_result_vld;
   logic                 r_busy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_fcnt <= '0;
      else if (r_fcnt == c_last)
         r_fcnt <= '0;
      else
         r_fcnt <= r_fcnt + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= S_PICK;
      else
         r_state <= w_state_nxt;
   end

   // Descending scan so the nearest enabled channel after r_cur wins; k=4 is r_cur itself.
   always_comb begin
      w_found   = 1'b0;
      w_pick_ch = r_cur;
      for (int k = 4; k >= 1; k--) begin
         if (i_ch_en[r_cur + 2'(k)]) begin
            w_found   = 1'b1;
            w_pick_ch = r_cur + 2'(k);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_cap_at    = (r_cur == 2'd0) ? c_dust_at : c_settle_at;
      case (r_state)
         S_PICK: w_state_nxt = w_found ? S_WAIT : S_HOLD;
         S_WAIT: begin
            if (r_fcnt == w_cap_at) begin
               w_capture   = 1'b1;
               w_state_nxt = (r_fcnt == c_last) ? S_PICK : S_HOLD;
            end
         end
         S_HOLD: begin
            if (r_fcnt == c_last)
               w_state_nxt = S_PICK;
         end
         default: w_state_nxt = S_PICK;
      endcase
   end

   assign w_sum = r_acc[r_cap_ch] + {{AVG_LOG2{1'b0}}, r_sample};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cur        <= 2'd3;
         r_mux_sel    <= 2'd0;
         r_led_en     <= 1'b1;
         r_busy       <= 1'b0;
         r_sample     <= 8'd0;
         r_cap_vld    <= 1'b0;
         r_cap_ch     <= 2'd0;
         r_result     <= 8'd0;
         r_result_ch  <= 2'd0;
         r_result_vld <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            r_acc[n] <= '0;
            r_cnt[n] <= '0;
         end
      end else begin
         r_result_vld <= 1'b0;
         r_cap_vld    <= w_capture;
         if (w_capture) begin
            r_sample <= i_adc_data;
            r_cap_ch <= r_cur;
         end

         if (r_state == S_PICK) begin
            if (w_found) begin
               r_cur     <= w_pick_ch;
               r_mux_sel <= w_pick_ch;
            end
            r_busy   <= w_found;
            r_led_en <= !(w_found && (w_pick_ch == 2'd0));
         end else begin
            if (w_capture)
               r_busy <= 1'b0;
            if (!r_led_en && (r_fcnt >= c_led_end))
               r_led_en <= 1'b1;
         end

         if (r_cap_vld) begin
            r_cnt[r_cap_ch] <= r_cnt[r_cap_ch] + 1'b1;
            if (&r_cnt[r_cap_ch]) begin
               r_acc[r_cap_ch] <= '0;
               r_result        <= 8'(w_sum >> AVG_LOG2);
               r_result_ch     <= r_cap_ch;
               r_result_vld    <= 1'b1;
            end else begin
               r_acc[r_cap_ch] <= w_sum;
            end
         end

         // Disabled channels lose their partial sums; placed last so the clear wins.
         if (r_state == S_PICK) begin
            for (int n = 0; n < 4; n++) begin
               if (!i_ch_en[n]) begin
                  r_acc[n] <= '0;
                  r_cnt[n] <= '0;
               end
            end
         end
      end
   end

   assign o_mux_sel    = r_mux_sel;
   assign o_led_en     = r_led_en;
   assign o_result     = r_result;
   assign o_result_ch  = r_result_ch;
   assign o_result_vld = r_result_vld;
   assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sensor_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sensor_scan_ctrl                                              |
// | Purpose : Self-checking bench for sensor_scan_ctrl against a frame model.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sensor_scan_ctrl;

   localparam int P      = 100;
   localparam int LED    = 32;
   localparam int DUST   = 30;
   localparam int SETTLE = 10;
   localparam int AVG    = 2;
   localparam int NAVG   = 1 << AVG;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] adc   = 8'd0;
   logic [3:0] en    = 4'd0;
   logic [1:0] mux;
   logic       led;
   logic [7:0] res;
   logic [1:0] res_ch;
   logic       vld;
   logic       busy;

   int n_run    = 0;
   int n_fail   = 0;
   int vld_seen = 0;

   // Frame-level model: phase within frame, selected channel, per-channel sums.
   int m_ph, m_c, m_cur, m_mux, m_sel, m_vld_c;
   int m_pend_res, m_pend_ch, m_res, m_res_ch;
   int m_sum [4];
   int m_n   [4];

   sensor_scan_ctrl #(
      .PERIOD_CYC     (P),
      .LED_ON_CYC     (LED),
      .DUST_SAMPLE_AT (DUST),
      .SETTLE_CYC     (SETTLE),
      .AVG_LOG2       (AVG)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_adc_data   (adc),
      .i_ch_en      (en),
      .o_mux_sel    (mux),
      .o_led_en     (led),
      .o_result     (res),
      .o_result_ch  (res_ch),
      .o_result_vld (vld),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, m_c, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_ph = 0; m_c = 0; m_cur = 3; m_mux = 0; m_sel = 0; m_vld_c = -1;
      m_pend_res = 0; m_pend_ch = 0; m_res = 0; m_res_ch = 0;
      for (int n = 0; n < 4; n++) begin
         m_sum[n] = 0;
         m_n[n]   = 0;
      end
   endfunction

   task automatic check_reset_outputs();
      check("rst_mux_sel", mux, 0);
      check("rst_led_en", led, 1);
      check("rst_result", res, 0);
      check("rst_result_ch", res_ch, 0);
      check("rst_result_vld", vld, 0);
      check("rst_busy", busy, 0);
   endtask

   // One clock cycle: apply inputs, advance model, compare all outputs.
   task automatic tick(input logic [3:0] e, input logic [7:0] d);
      int cap;
      en  = e;
      adc = d;
      if (m_ph == 0) begin
         for (int n = 0; n < 4; n++) begin
            if (!e[n]) begin
               m_sum[n] = 0;
               m_n[n]   = 0;
            end
         end
         m_sel = 0;
         for (int k = 1; k <= 4; k++) begin
            if (m_sel == 0 && e[(m_cur + k) % 4]) begin
               m_sel = 1;
               m_cur = (m_cur + k) % 4;
            end
         end
         if (m_sel != 0) m_mux = m_cur;
      end else begin
         cap = (m_cur == 0) ? DUST : SETTLE;
         if (m_sel != 0 && m_ph == cap) begin
            m_sum[m_cur] += int'(d);
            m_n[m_cur]++;
            if (m_n[m_cur] == NAVG) begin
               m_pend_res   = m_sum[m_cur] / NAVG;
               m_pend_ch    = m_cur;
               m_vld_c      = m_c + 2;
               m_sum[m_cur] = 0;
               m_n[m_cur]   = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      m_c++;
      m_ph = (m_ph + 1) % P;
      if (m_c == m_vld_c) begin
         m_res    = m_pend_res;
         m_res_ch = m_pend_ch;
      end
      if (vld === 1'b1) vld_seen++;
      cap = (m_cur == 0) ? DUST : SETTLE;
      check("mux_sel", mux, m_mux);
      check("led_en", led, (m_sel != 0 && m_cur == 0 && m_ph >= 1 && m_ph <= LED) ? 0 : 1);
      check("busy", busy, (m_sel != 0 && m_ph >= 1 && m_ph <= cap) ? 1 : 0);
      check("result_vld", vld, (m_c == m_vld_c) ? 1 : 0);
      check("result", res, m_res);
      check("result_ch", res_ch, m_res_ch);
   endtask

   task automatic run_frames(input int nf, input logic [3:0] e, input bit rnd, input logic [7:0] d);
      for (int i = 0; i < nf * P; i++)
         tick(e, rnd ? 8'($urandom) : d);
   endtask

   initial begin
      int tbl [4];
      tbl = '{10, 20, 30, 41};
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      model_reset();

      // Dust channel only, constant sample.
      vld_seen = 0;
      run_frames(4, 4'b0001, 1'b0, 8'h40);
      check("avg_ch0_value", res, 8'h40);
      check("avg_ch0_ch", res_ch, 0);
      check("avg_ch0_vld_count", vld_seen, 1);

      // Alternating channels 1 and 3.
      run_frames(4, 4'b1010, 1'b1, 8'h00);

      // Nothing enabled.
      vld_seen = 0;
      run_frames(10, 4'b0000, 1'b1, 8'h00);
      check("idle_vld_count", vld_seen, 0);

      // Truncating average on channel 1.
      for (int i = 0; i < 4; i++)
         run_frames(1, 4'b0010, 1'b0, 8'(tbl[i]));
      check("trunc_value", res, 25);
      check("trunc_ch", res_ch, 1);

      // Stale partial sum discarded on channel 2.
      vld_seen = 0;
      run_frames(2, 4'b0100, 1'b1, 8'h00);
      run_frames(1, 4'b0000, 1'b1, 8'h00);
      run_frames(3, 4'b0100, 1'b1, 8'h00);
      check("stale_no_result", vld_seen, 0);
      run_frames(1, 4'b0100, 1'b1, 8'h00);
      check("stale_first_result", vld_seen, 1);
      check("stale_result_ch", res_ch, 2);

      // Random enables per frame, random data per cycle.
      for (int f = 0; f < 20; f++)
         run_frames(1, 4'($urandom_range(0, 15)), 1'b1, 8'h00);

      // Asynchronous reset in the middle of a dust frame.
      for (int i = 0; i < 20; i++)
         tick(4'b0001, 8'($urandom));
      check("pre_rst_led_low", led, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_led_async", led, 1);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      model_reset();
      tick(4'b1111, 8'($urandom));
      check("first_pick_ch0", mux, 0);
      for (int i = 0; i < 2 * P - 1; i++)
         tick(4'b1111, 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
